// File: rtl/relu_pool_stream_param.sv
// Streaming activation, round/saturate quantiser and non-overlapping K x K max-pool for NUM_CH
// parallel channels. Two registered stages with valid/ready backpressure on both sides.
module relu_pool_stream_param #(
    parameter int NUM_CH          = 4,
    parameter int ACC_W           = 32,
    parameter int DATA_WIDTH      = 8,
    parameter int FRAC_SHIFT      = 6,
    parameter int LEAKY_SHIFT     = 3,
    parameter int MAP_W           = 24,
    parameter int MAP_H           = 24,
    parameter int POOL_K          = 2,
    parameter int POOL_ADDR_WIDTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [1:0]                   act_mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH*ACC_W-1:0]      in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [POOL_ADDR_WIDTH-1:0]   out_addr,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int PW  = MAP_W / POOL_K;
    localparam int PH  = MAP_H / POOL_K;
    localparam int KW  = (POOL_K > 1) ? $clog2(POOL_K) : 1;
    localparam int PCW = (PW > 1) ? $clog2(PW) : 1;
    localparam int PRW = (PH > 1) ? $clog2(PH) : 1;

    localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(OUT_MAX);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(OUT_MIN);
    // Half an output LSB; evaluates to zero when FRAC_SHIFT is 0.
    localparam logic signed [ACC_W:0] RND = ((ACC_W+1)'(1) << FRAC_SHIFT) >> 1;

    if ((MAP_W % POOL_K) != 0 || (MAP_H % POOL_K) != 0) begin : g_bad_map
        $error("MAP_W and MAP_H must be multiples of POOL_K");
    end
    if ((PW * PH - 1) >= (2 ** POOL_ADDR_WIDTH)) begin : g_bad_addr
        $error("POOL_ADDR_WIDTH too small for pooled map");
    end
    if (FRAC_SHIFT < 0 || FRAC_SHIFT > ACC_W - 2) begin : g_bad_shift
        $error("FRAC_SHIFT out of range");
    end

    function automatic logic signed [DATA_WIDTH-1:0] quantise(
        input logic signed [ACC_W-1:0] x,
        input logic [1:0]              mode
    );
        logic signed [ACC_W-1:0] a;
        logic signed [ACC_W:0]   q;
        case (mode)
            2'd0:    a = x;
            2'd2:    a = x[ACC_W-1] ? (x >>> LEAKY_SHIFT) : x;
            default: a = x[ACC_W-1] ? '0 : x;
        endcase
        q = ($signed({a[ACC_W-1], a}) + RND) >>> FRAC_SHIFT;
        if (q > SAT_MAX)
            return OUT_MAX;
        else if (q < SAT_MIN)
            return OUT_MIN;
        else
            return q[DATA_WIDTH-1:0];
    endfunction

    logic                       busy_reg, in_done_reg, frame_done_reg;
    logic [1:0]                 mode_reg;
    logic [KW-1:0]              kx_reg, ky_reg;
    logic [PCW-1:0]             pcol_reg;
    logic [PRW-1:0]             prow_reg;
    logic                       s1_valid_reg, s1_first_reg, s1_last_reg;
    logic [PCW-1:0]             s1_idx_reg;
    logic [POOL_ADDR_WIDTH-1:0] s1_addr_reg;
    logic                       out_valid_reg;
    logic [POOL_ADDR_WIDTH-1:0] out_addr_reg;
    logic [NUM_CH*DATA_WIDTH-1:0] out_data_reg;
    logic [NUM_CH*DATA_WIDTH-1:0] pool_flat;

    logic stall, accept, final_hs;
    logic kx_wrap, ky_wrap, pcol_wrap, prow_wrap;

    assign stall     = out_valid_reg & ~out_ready;
    assign in_ready  = busy_reg & ~in_done_reg & ~stall;
    assign accept    = in_valid & in_ready & ~start;
    assign final_hs  = out_valid_reg & out_ready & (out_addr_reg == POOL_ADDR_WIDTH'(PW * PH - 1));
    assign kx_wrap   = (kx_reg == KW'(POOL_K - 1));
    assign ky_wrap   = (ky_reg == KW'(POOL_K - 1));
    assign pcol_wrap = (pcol_reg == PCW'(PW - 1));
    assign prow_wrap = (prow_reg == PRW'(PH - 1));

    assign out_valid  = out_valid_reg;
    assign out_addr   = out_addr_reg;
    assign out_data   = out_data_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_reg       <= 1'b0;
            in_done_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            mode_reg       <= 2'd0;
            kx_reg         <= '0;
            ky_reg         <= '0;
            pcol_reg       <= '0;
            prow_reg       <= '0;
            s1_valid_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_addr_reg   <= '0;
            out_data_reg   <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            if (start) begin
                // Abort/begin: everything in flight is discarded.
                busy_reg      <= 1'b1;
                in_done_reg   <= 1'b0;
                mode_reg      <= act_mode;
                kx_reg        <= '0;
                ky_reg        <= '0;
                pcol_reg      <= '0;
                prow_reg      <= '0;
                s1_valid_reg  <= 1'b0;
                out_valid_reg <= 1'b0;
            end else begin
                if (accept) begin
                    if (kx_wrap) begin
                        kx_reg <= '0;
                        if (pcol_wrap) begin
                            pcol_reg <= '0;
                            if (ky_wrap) begin
                                ky_reg <= '0;
                                if (prow_wrap) begin
                                    prow_reg    <= '0;
                                    in_done_reg <= 1'b1;
                                end else begin
                                    prow_reg <= prow_reg + 1'b1;
                                end
                            end else begin
                                ky_reg <= ky_reg + 1'b1;
                            end
                        end else begin
                            pcol_reg <= pcol_reg + 1'b1;
                        end
                    end else begin
                        kx_reg <= kx_reg + 1'b1;
                    end
                end
                if (!stall) begin
                    s1_valid_reg  <= accept;
                    out_valid_reg <= s1_valid_reg & s1_last_reg;
                    if (s1_valid_reg && s1_last_reg) begin
                        out_addr_reg <= s1_addr_reg;
                        out_data_reg <= pool_flat;
                    end
                end
                if (final_hs) begin
                    busy_reg       <= 1'b0;
                    in_done_reg    <= 1'b0;
                    frame_done_reg <= 1'b1;
                end
            end
        end
    end

    // Window position tags travel with the S1 payload.
    always_ff @(posedge clock) begin
        if (accept) begin
            s1_first_reg <= (kx_reg == '0) && (ky_reg == '0);
            s1_last_reg  <= kx_wrap && ky_wrap;
            s1_idx_reg   <= pcol_reg;
            s1_addr_reg  <= POOL_ADDR_WIDTH'(int'(prow_reg) * PW + int'(pcol_reg));
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic signed [DATA_WIDTH-1:0] y_next;
        logic signed [DATA_WIDTH-1:0] s1_y_reg;
        logic signed [DATA_WIDTH-1:0] buf_rd;
        logic signed [DATA_WIDTH-1:0] pool_cur;
        logic signed [DATA_WIDTH-1:0] max_buf [PW];

        always_comb begin
            y_next = quantise(in_data[gi*ACC_W +: ACC_W], mode_reg);
        end

        always_ff @(posedge clock) begin
            if (accept)
                s1_y_reg <= y_next;
        end

        // First pixel of a window replaces whatever the buffer held.
        always_comb begin
            buf_rd   = max_buf[s1_idx_reg];
            pool_cur = (s1_first_reg || (s1_y_reg > buf_rd)) ? s1_y_reg : buf_rd;
        end

        always_ff @(posedge clock) begin
            if (s1_valid_reg && !stall)
                max_buf[s1_idx_reg] <= pool_cur;
        end

        assign pool_flat[gi*DATA_WIDTH +: DATA_WIDTH] = pool_cur;
    end

endmodule

// File: tb/tb_relu_pool_stream_param.sv
// Randomised bench for relu_pool_stream_param: a pooling instance (4x4, K=2, 2 ch) and a
// pass-through instance (3x3, K=1, 4 ch), both FRAC_SHIFT=6, checked against an arithmetic model.
module tb_relu_pool_stream_param;

    localparam int AW = 32;
    localparam int DW = 8;
    localparam int P_CH = 2;
    localparam int K_CH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic                 p_start, p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_busy, p_frame_done;
    logic [1:0]           p_mode;
    logic [P_CH*AW-1:0]   p_in_data;
    logic [7:0]           p_out_addr;
    logic [P_CH*DW-1:0]   p_out_data;

    logic                 k_start, k_in_valid, k_in_ready, k_out_valid, k_out_ready, k_busy, k_frame_done;
    logic [1:0]           k_mode;
    logic [K_CH*AW-1:0]   k_in_data;
    logic [3:0]           k_out_addr;
    logic [K_CH*DW-1:0]   k_out_data;

    relu_pool_stream_param #(
        .NUM_CH(P_CH), .ACC_W(AW), .DATA_WIDTH(DW), .FRAC_SHIFT(6), .LEAKY_SHIFT(3),
        .MAP_W(4), .MAP_H(4), .POOL_K(2), .POOL_ADDR_WIDTH(8)
    ) dut_p (
        .clock(clk), .reset(rst), .start(p_start), .act_mode(p_mode),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_addr(p_out_addr),
        .out_data(p_out_data), .busy(p_busy), .frame_done(p_frame_done)
    );

    relu_pool_stream_param #(
        .NUM_CH(K_CH), .ACC_W(AW), .DATA_WIDTH(DW), .FRAC_SHIFT(6), .LEAKY_SHIFT(3),
        .MAP_W(3), .MAP_H(3), .POOL_K(1), .POOL_ADDR_WIDTH(4)
    ) dut_k (
        .clock(clk), .reset(rst), .start(k_start), .act_mode(k_mode),
        .in_valid(k_in_valid), .in_ready(k_in_ready), .in_data(k_in_data),
        .out_valid(k_out_valid), .out_ready(k_out_ready), .out_addr(k_out_addr),
        .out_data(k_out_data), .busy(k_busy), .frame_done(k_frame_done)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: activation, round-half-up to 2^-6, clamp to int8.
    function automatic longint qref(input longint x, input int mode);
        longint a, y;
        if (mode == 0)      a = x;
        else if (mode == 2) a = (x < 0) ? -((-x + 7) / 8) : x;
        else                a = (x < 0) ? 0 : x;
        y = a + 32;
        y = (y >= 0) ? y / 64 : -((-y + 63) / 64);
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return y;
    endfunction

    function automatic longint rnd();
        if ($urandom_range(0, 1) == 1)
            return longint'($urandom_range(0, 40000)) - 20000;
        return longint'($urandom_range(0, 400000)) - 200000;
    endfunction

    longint pf [16][P_CH];
    longint kf [9][K_CH];

    // Output monitors: collect handshakes, count frame_done, check hold behaviour during stalls.
    int                 p_got_addr[$];
    logic [P_CH*DW-1:0] p_got_data[$];
    int                 p_done_cnt = 0;
    logic               p_stall_prev = 1'b0;
    logic [7:0]         p_prev_addr;
    logic [P_CH*DW-1:0] p_prev_data;

    always @(negedge clk) begin
        if (rst) begin
            p_stall_prev <= 1'b0;
        end else begin
            if (p_out_valid && p_out_ready) begin
                p_got_addr.push_back(int'(p_out_addr));
                p_got_data.push_back(p_out_data);
            end
            if (p_frame_done) p_done_cnt <= p_done_cnt + 1;
            if (p_stall_prev) begin
                check("hold_valid", p_out_valid, 1);
                check("hold_addr", p_out_addr, p_prev_addr);
                check("hold_data", p_out_data, p_prev_data);
            end
            if (p_out_valid && !p_out_ready) check("stall_in_ready", p_in_ready, 0);
            p_stall_prev <= p_out_valid && !p_out_ready;
            p_prev_addr  <= p_out_addr;
            p_prev_data  <= p_out_data;
        end
    end

    int                 k_got_addr[$];
    logic [K_CH*DW-1:0] k_got_data[$];
    int                 k_got_cyc[$];
    int                 k_acc_cyc[$];
    int                 k_done_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (k_out_valid && k_out_ready) begin
                k_got_addr.push_back(int'(k_out_addr));
                k_got_data.push_back(k_out_data);
                k_got_cyc.push_back(cyc + 1);
            end
            if (k_frame_done) k_done_cnt <= k_done_cnt + 1;
        end
    end

    // Consumer readiness for the pooling instance.
    bit hold_first = 1'b0;
    int hold_cnt = 0;
    bit bp_random = 1'b0;
    always @(posedge clk) begin
        #1;
        if (hold_first && p_out_valid) begin
            hold_first = 1'b0;
            hold_cnt = 10;
        end
        if (hold_cnt > 0) begin
            p_out_ready = 1'b0;
            hold_cnt--;
        end else if (bp_random) begin
            p_out_ready = ($urandom_range(0, 2) != 0);
        end else begin
            p_out_ready = 1'b1;
        end
    end

    // All drivers run in the phase just after a rising edge.
    task automatic push(input bit to_k, input logic [127:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        if (to_k) begin k_in_valid = 1'b1; k_in_data = d; end
        else      begin p_in_valid = 1'b1; p_in_data = d[P_CH*AW-1:0]; end
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = to_k ? k_in_ready : p_in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (to_k) begin k_in_valid = 1'b0; k_acc_cyc.push_back(cyc); end
        else      p_in_valid = 1'b0;
        check("push_accept", acc, 1);
    endtask

    task automatic do_start(input bit to_k, input logic [1:0] m);
        if (to_k) begin k_start = 1'b1; k_mode = m; end
        else      begin p_start = 1'b1; p_mode = m; end
        @(posedge clk);
        #1;
        k_start = 1'b0;
        p_start = 1'b0;
    endtask

    task automatic send_p(input int count, input bit gaps);
        logic [127:0] d;
        for (int i = 0; i < count; i++) begin
            d = '0;
            for (int c = 0; c < P_CH; c++) d[c*AW +: AW] = 32'(pf[i][c]);
            push(1'b0, d);
            if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic send_k();
        logic [127:0] d;
        for (int i = 0; i < 9; i++) begin
            d = '0;
            for (int c = 0; c < K_CH; c++) d[c*AW +: AW] = 32'(kf[i][c]);
            push(1'b1, d);
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic fill_p();
        for (int i = 0; i < 16; i++)
            for (int c = 0; c < P_CH; c++) pf[i][c] = rnd();
    endtask

    task automatic fill_k();
        for (int i = 0; i < 9; i++)
            for (int c = 0; c < K_CH; c++) kf[i][c] = rnd();
    endtask

    task automatic wait_done(input bit to_k, input int target);
        int n;
        n = 0;
        while (((to_k ? k_done_cnt : p_done_cnt) < target) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) begin @(posedge clk); #1; end
    endtask

    // Pooled expectation: max over each 2x2 window of the quantised inputs.
    task automatic expect_p(input string tag, input int mode, input int target);
        longint m, v;
        logic [P_CH*DW-1:0] e;
        wait_done(1'b0, target);
        check({tag, "_frame_done_cnt"}, p_done_cnt, target);
        check({tag, "_busy_after"}, p_busy, 0);
        check({tag, "_out_count"}, p_got_addr.size(), 4);
        for (int o = 0; o < 4 && o < p_got_addr.size(); o++) begin
            check({tag, "_addr"}, p_got_addr[o], o);
            e = p_got_data[o];
            for (int c = 0; c < P_CH; c++) begin
                m = -1000;
                for (int dy = 0; dy < 2; dy++)
                    for (int dx = 0; dx < 2; dx++) begin
                        v = qref(pf[((o / 2) * 2 + dy) * 4 + (o % 2) * 2 + dx][c], mode);
                        if (v > m) m = v;
                    end
                check({tag, "_data"}, $signed(e[c*DW +: DW]), m);
            end
        end
    endtask

    task automatic expect_k(input string tag, input int mode, input int target);
        logic [K_CH*DW-1:0] e;
        wait_done(1'b1, target);
        check({tag, "_frame_done_cnt"}, k_done_cnt, target);
        check({tag, "_out_count"}, k_got_addr.size(), 9);
        for (int o = 0; o < 9 && o < k_got_addr.size(); o++) begin
            check({tag, "_addr"}, k_got_addr[o], o);
            check({tag, "_latency"}, k_got_cyc[o] - k_acc_cyc[o], 2);
            e = k_got_data[o];
            for (int c = 0; c < K_CH; c++)
                check({tag, "_data"}, $signed(e[c*DW +: DW]), qref(kf[o][c], mode));
        end
    endtask

    task automatic check_t1_consts(input string tag);
        int exp1 [4];
        logic [P_CH*DW-1:0] e;
        exp1 = '{5, 7, 13, 15};
        for (int o = 0; o < 4 && o < p_got_data.size(); o++) begin
            e = p_got_data[o];
            check({tag, "_ch0_const"}, $signed(e[DW-1:0]), exp1[o]);
        end
    endtask

    task automatic clear_q();
        p_got_addr.delete(); p_got_data.delete();
        k_got_addr.delete(); k_got_data.delete(); k_got_cyc.delete(); k_acc_cyc.delete();
    endtask

    logic [K_CH*DW-1:0] ke;

    initial begin
        rst = 1'b1;
        p_start = 1'b0; p_mode = 2'd0; p_in_valid = 1'b0; p_in_data = '0; p_out_ready = 1'b1;
        k_start = 1'b0; k_mode = 2'd0; k_in_valid = 1'b0; k_in_data = '0; k_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", p_in_ready, 0);
        check("rst_out_valid", p_out_valid, 0);
        check("rst_out_addr", p_out_addr, 0);
        check("rst_out_data", p_out_data, 0);
        check("rst_busy", p_busy, 0);
        check("rst_frame_done", p_frame_done, 0);
        check("rst_k_out_valid", k_out_valid, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Raster ramp 0..15 (scaled by 2^6), ReLU.
        for (int i = 0; i < 16; i++) begin
            pf[i][0] = longint'(i) * 64;
            pf[i][1] = rnd();
        end
        do_start(1'b0, 2'd1);
        check("busy_after_start", p_busy, 1);
        send_p(16, 1'b1);
        expect_p("ramp", 1, 1);
        check_t1_consts("ramp");
        clear_q();

        // Leaky window {-64,-16,-80,-8} scaled by 2^6 -> -1.
        fill_p();
        pf[0][0] = -4096; pf[1][0] = -1024; pf[4][0] = -5120; pf[5][0] = -512;
        do_start(1'b0, 2'd2);
        send_p(16, 1'b1);
        expect_p("leaky", 2, 2);
        if (p_got_data.size() > 0) begin
            ke = '0;
            ke[P_CH*DW-1:0] = p_got_data[0];
            check("leaky_window0", $signed(ke[DW-1:0]), -1);
        end
        clear_q();

        // Consumer holds off the first output for 10 cycles.
        fill_p();
        hold_first = 1'b1;
        do_start(1'b0, 2'd1);
        send_p(16, 1'b1);
        expect_p("backpressure", 1, 3);
        check("backpressure_hold_used", hold_first, 0);
        clear_q();

        // Abort after 6 pixels (window 0 just completed); start coincides with a stray pixel.
        fill_p();
        do_start(1'b0, 2'd0);
        send_p(6, 1'b0);
        p_start = 1'b1; p_mode = 2'd1; p_in_valid = 1'b1; p_in_data = '1;
        @(posedge clk);
        #1;
        p_start = 1'b0; p_in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pf[i][0] = longint'(i) * 64;
            pf[i][1] = rnd();
        end
        bp_random = 1'b1;
        send_p(16, 1'b1);
        expect_p("abort", 1, 4);
        check_t1_consts("abort");
        bp_random = 1'b0;
        clear_q();

        // Quantiser corners through the K=1 instance: bypass then ReLU.
        fill_k();
        kf[0][0] = 95; kf[0][1] = 96; kf[0][2] = 100000; kf[0][3] = -1000000;
        do_start(1'b1, 2'd0);
        send_k();
        expect_k("quant_bypass", 0, 1);
        if (k_got_data.size() > 0) begin
            ke = k_got_data[0];
            check("q95", $signed(ke[0*DW +: DW]), 1);
            check("q96", $signed(ke[1*DW +: DW]), 2);
            check("q_sat_hi", $signed(ke[2*DW +: DW]), 127);
            check("q_sat_lo", $signed(ke[3*DW +: DW]), -128);
        end
        clear_q();
        do_start(1'b1, 2'd1);
        send_k();
        expect_k("quant_relu", 1, 2);
        if (k_got_data.size() > 0) begin
            ke = k_got_data[0];
            check("q_relu_neg", $signed(ke[3*DW +: DW]), 0);
        end
        clear_q();
        fill_k();
        do_start(1'b1, 2'd2);
        send_k();
        expect_k("k1_leaky", 2, 3);
        fill_k();
        clear_q();
        do_start(1'b1, 2'd3);
        send_k();
        expect_k("k1_mode3", 1, 4);
        clear_q();

        // Reset in the middle of a frame.
        fill_p();
        do_start(1'b0, 2'd1);
        send_p(5, 1'b0);
        check("pre_reset_busy", p_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", p_busy, 0);
        check("midrst_in_ready", p_in_ready, 0);
        check("midrst_out_valid", p_out_valid, 0);
        check("midrst_out_addr", p_out_addr, 0);
        check("midrst_out_data", p_out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("midrst_no_output", p_got_addr.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
